// File: rtl/text_buffer_writer.sv
// Character-grid text buffer: stores encoded character ids at a wrapping cursor,
// serves a registered read port, and blanks the whole grid on reset or request.
module text_buffer_writer #(
  parameter int         COLS       = 80,
  parameter int         ROWS       = 30,
  parameter logic [7:0] BLANK_ID   = 8'd255,
  parameter logic [7:0] INVALID_ID = 8'd128,
  localparam int        COL_W      = $clog2(COLS),
  localparam int        ROW_W      = $clog2(ROWS)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [7:0]       character_id,
  input  logic             char_valid,
  input  logic             clear_req,
  input  logic [COL_W-1:0] rd_col,
  input  logic [ROW_W-1:0] rd_row,
  output logic [7:0]       rd_data,
  output logic [COL_W-1:0] cursor_col,
  output logic [ROW_W-1:0] cursor_row,
  output logic             busy,
  output logic             char_dropped
);

  localparam int                CELLS     = COLS * ROWS;
  localparam int                ADDR_W    = $clog2(CELLS);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(CELLS - 1);
  localparam logic [ADDR_W-1:0] COLS_A    = ADDR_W'(COLS);
  localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(ROWS - 1);

  typedef enum logic {CLEAR, IDLE} state_t;

  state_t            state, state_next;
  logic [ADDR_W-1:0] sweep_addr, sweep_next;
  logic [ADDR_W-1:0] cursor_addr, rd_addr, wr_addr;
  logic [COL_W-1:0]  col_next;
  logic [ROW_W-1:0]  row_next;
  logic [7:0]        wr_data;
  logic              we, drop, rd_in_range;
  logic [7:0]        mem [CELLS];

  assign busy        = (state == CLEAR);
  assign cursor_addr = ADDR_W'(cursor_row) * COLS_A + ADDR_W'(cursor_col);
  assign rd_addr     = ADDR_W'(rd_row) * COLS_A + ADDR_W'(rd_col);
  assign rd_in_range = (int'(rd_col) < COLS) && (int'(rd_row) < ROWS);

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    state_next = state;
    sweep_next = sweep_addr;
    col_next   = cursor_col;
    row_next   = cursor_row;
    we         = 1'b0;
    wr_addr    = cursor_addr;
    wr_data    = character_id;
    drop       = 1'b0;
    case (state)
      CLEAR: begin
        we         = 1'b1;
        wr_addr    = sweep_addr;
        wr_data    = BLANK_ID;
        drop       = char_valid;
        sweep_next = sweep_addr + 1'b1;
        if (sweep_addr == LAST_ADDR) begin
          state_next = IDLE;
          sweep_next = '0;
        end
      end
      IDLE: begin
        if (clear_req) begin
          state_next = CLEAR;
          sweep_next = '0;
          col_next   = '0;
          row_next   = '0;
          drop       = char_valid;
        end else if (char_valid && character_id != INVALID_ID) begin
          we = 1'b1;
          if (cursor_col == LAST_COL) begin
            col_next = '0;
            row_next = (cursor_row == LAST_ROW) ? '0 : cursor_row + 1'b1;
          end else begin
            col_next = cursor_col + 1'b1;
          end
        end
      end
      default: state_next = CLEAR;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= CLEAR;
      sweep_addr   <= '0;
      cursor_col   <= '0;
      cursor_row   <= '0;
      char_dropped <= 1'b0;
    end else begin
      state        <= state_next;
      sweep_addr   <= sweep_next;
      cursor_col   <= col_next;
      cursor_row   <= row_next;
      char_dropped <= drop;
    end
  end

  // NOTE: the RAM array has no reset; the clear sweep blanks it, keeping it mappable to block RAM.
  always_ff @(posedge clock) begin
    if (we && !reset) mem[wr_addr] <= wr_data;
  end

  // Read-first: this read sees the cell contents from before a same-edge write.
  always_ff @(posedge clock) begin
    if (reset)            rd_data <= BLANK_ID;
    else if (rd_in_range) rd_data <= mem[rd_addr];
    else                  rd_data <= BLANK_ID;
  end

endmodule

// File: tb/tb_text_buffer_writer.sv
// Directed self-checking bench for text_buffer_writer at default 80x30 geometry.
module tb_text_buffer_writer;

  localparam int COL_W = 7;
  localparam int ROW_W = 5;

  logic             clock = 1'b0;
  logic             reset;
  logic [7:0]       character_id;
  logic             char_valid;
  logic             clear_req;
  logic [COL_W-1:0] rd_col;
  logic [ROW_W-1:0] rd_row;
  logic [7:0]       rd_data;
  logic [COL_W-1:0] cursor_col;
  logic [ROW_W-1:0] cursor_row;
  logic             busy;
  logic             char_dropped;

  int total = 0;
  int bad   = 0;

  text_buffer_writer dut (
    .clock(clock), .reset(reset), .character_id(character_id),
    .char_valid(char_valid), .clear_req(clear_req),
    .rd_col(rd_col), .rd_row(rd_row), .rd_data(rd_data),
    .cursor_col(cursor_col), .cursor_row(cursor_row),
    .busy(busy), .char_dropped(char_dropped)
  );

  always #5 clock = ~clock;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(negedge clock);
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy === 1'b1 && n < 3000) begin
      tick();
      n++;
    end
  endtask

  task automatic read_cell(input int r, input int c, output logic [7:0] v);
    rd_row = ROW_W'(r);
    rd_col = COL_W'(c);
    tick();
    v = rd_data;
  endtask

  task automatic send(input logic [7:0] id);
    char_valid   = 1'b1;
    character_id = id;
    tick();
    char_valid   = 1'b0;
  endtask

  task automatic test_reset();
    int n, errs;
    logic [7:0] v;
    reset = 1'b1;
    tick(); tick();
    total++;
    if (busy !== 1'b1 || rd_data !== 8'd255 || char_dropped !== 1'b0) begin
      $display("FAIL reset_outputs got busy=%b rd=%0d drop=%b exp busy=1 rd=255 drop=0",
               busy, rd_data, char_dropped); bad++;
    end
    reset = 1'b0;
    wait_idle(n);
    total++;
    if (n !== 2400) begin $display("FAIL reset_busy_len got=%0d exp=2400", n); bad++; end
    total++;
    if (cursor_col !== 0 || cursor_row !== 0) begin
      $display("FAIL reset_cursor got=(%0d,%0d) exp=(0,0)", cursor_row, cursor_col); bad++;
    end
    errs = 0;
    for (int r = 0; r < 30; r++)
      for (int c = 0; c < 80; c++) begin
        read_cell(r, c, v);
        if (v !== 8'd255) errs++;
      end
    total++;
    if (errs !== 0) begin $display("FAIL reset_all_blank got=%0d bad cells exp=0", errs); bad++; end
  endtask

  task automatic test_basic_write();
    logic [7:0] v;
    send(8'd10); send(8'd11); send(8'd12);
    total++;
    if (cursor_col !== 3 || cursor_row !== 0) begin
      $display("FAIL basic_cursor got=(%0d,%0d) exp=(0,3)", cursor_row, cursor_col); bad++;
    end
    for (int c = 0; c < 3; c++) begin
      read_cell(0, c, v);
      total++;
      if (v !== 8'(10 + c)) begin $display("FAIL basic_cell_%0d got=%0d exp=%0d", c, v, 10 + c); bad++; end
    end
  endtask

  task automatic test_row_wrap();
    int n, errs;
    logic [7:0] v;
    clear_req = 1'b1; tick(); clear_req = 1'b0;
    wait_idle(n);
    total++;
    if (n !== 2400) begin $display("FAIL req_clear_len got=%0d exp=2400", n); bad++; end
    repeat (80) send(8'd5);
    send(8'd7);
    total++;
    if (cursor_col !== 1 || cursor_row !== 1) begin
      $display("FAIL row_wrap_cursor got=(%0d,%0d) exp=(1,1)", cursor_row, cursor_col); bad++;
    end
    errs = 0;
    for (int c = 0; c < 80; c++) begin
      read_cell(0, c, v);
      if (v !== 8'd5) errs++;
    end
    total++;
    if (errs !== 0) begin $display("FAIL row0_fill got=%0d bad cells exp=0", errs); bad++; end
    read_cell(1, 0, v);
    total++;
    if (v !== 8'd7) begin $display("FAIL row1_col0 got=%0d exp=7", v); bad++; end
    repeat (2319) send(8'd6);
    total++;
    if (cursor_col !== 0 || cursor_row !== 0) begin
      $display("FAIL grid_wrap_cursor got=(%0d,%0d) exp=(0,0)", cursor_row, cursor_col); bad++;
    end
    read_cell(29, 79, v);
    total++;
    if (v !== 8'd6) begin $display("FAIL last_cell got=%0d exp=6", v); bad++; end
    send(8'd9);
    read_cell(0, 0, v);
    total++;
    if (v !== 8'd9 || cursor_col !== 1 || cursor_row !== 0) begin
      $display("FAIL wrap_write got cell=%0d cur=(%0d,%0d) exp cell=9 cur=(0,1)",
               v, cursor_row, cursor_col); bad++;
    end
  endtask

  task automatic test_invalid_id();
    logic [7:0] v;
    send(8'd128);
    total++;
    if (char_dropped !== 1'b0 || cursor_col !== 1 || cursor_row !== 0) begin
      $display("FAIL invalid_skip got drop=%b cur=(%0d,%0d) exp drop=0 cur=(0,1)",
               char_dropped, cursor_row, cursor_col); bad++;
    end
    read_cell(0, 1, v);
    total++;
    if (v !== 8'd5) begin $display("FAIL invalid_not_stored got=%0d exp=5", v); bad++; end
    send(8'd3);
    total++;
    if (char_dropped !== 1'b0) begin $display("FAIL valid_no_drop got=%b exp=0", char_dropped); bad++; end
    read_cell(0, 1, v);
    total++;
    if (v !== 8'd3 || cursor_col !== 2) begin
      $display("FAIL after_invalid got cell=%0d col=%0d exp cell=3 col=2", v, cursor_col); bad++;
    end
  endtask

  task automatic test_out_of_range();
    logic [7:0] v;
    read_cell(0, 80, v);
    total++;
    if (v !== 8'd255) begin $display("FAIL oob_col got=%0d exp=255", v); bad++; end
    read_cell(30, 0, v);
    total++;
    if (v !== 8'd255) begin $display("FAIL oob_row got=%0d exp=255", v); bad++; end
    read_cell(31, 127, v);
    total++;
    if (v !== 8'd255) begin $display("FAIL oob_max got=%0d exp=255", v); bad++; end
  endtask

  task automatic test_clear_with_char();
    int n;
    logic [7:0] v;
    clear_req = 1'b1; char_valid = 1'b1; character_id = 8'd20;
    tick();
    clear_req = 1'b0; char_valid = 1'b0;
    total++;
    if (char_dropped !== 1'b1 || busy !== 1'b1 || cursor_col !== 0 || cursor_row !== 0) begin
      $display("FAIL clear_char got drop=%b busy=%b cur=(%0d,%0d) exp drop=1 busy=1 cur=(0,0)",
               char_dropped, busy, cursor_row, cursor_col); bad++;
    end
    tick();
    total++;
    if (char_dropped !== 1'b0) begin $display("FAIL drop_one_cycle got=%b exp=0", char_dropped); bad++; end
    char_valid = 1'b1; character_id = 8'd21;
    tick();
    total++;
    if (char_dropped !== 1'b1) begin $display("FAIL busy_drop_1 got=%b exp=1", char_dropped); bad++; end
    character_id = 8'd22;
    tick();
    total++;
    if (char_dropped !== 1'b1) begin $display("FAIL busy_drop_2 got=%b exp=1", char_dropped); bad++; end
    char_valid = 1'b0;
    tick();
    total++;
    if (char_dropped !== 1'b0) begin $display("FAIL busy_drop_end got=%b exp=0", char_dropped); bad++; end
    wait_idle(n);
    total++;
    if (n + 4 !== 2400) begin $display("FAIL clear_char_len got=%0d exp=2400", n + 4); bad++; end
    read_cell(0, 2, v);
    total++;
    if (v !== 8'd255 || cursor_col !== 0 || cursor_row !== 0) begin
      $display("FAIL clear_char_cell got cell=%0d cur=(%0d,%0d) exp cell=255 cur=(0,0)",
               v, cursor_row, cursor_col); bad++;
    end
  endtask

  task automatic test_reset_mid_sweep();
    int n;
    logic [7:0] v;
    send(8'd40);
    clear_req = 1'b1; tick(); clear_req = 1'b0;
    repeat (1000) tick();
    reset = 1'b1; char_valid = 1'b1; character_id = 8'd50;
    rd_row = '0; rd_col = '0;
    tick();
    total++;
    if (rd_data !== 8'd255 || char_dropped !== 1'b0 || busy !== 1'b1) begin
      $display("FAIL mid_reset got rd=%0d drop=%b busy=%b exp rd=255 drop=0 busy=1",
               rd_data, char_dropped, busy); bad++;
    end
    reset = 1'b0; char_valid = 1'b0;
    wait_idle(n);
    total++;
    if (n !== 2400) begin $display("FAIL mid_reset_len got=%0d exp=2400", n); bad++; end
    read_cell(0, 0, v);
    total++;
    if (v !== 8'd255 || cursor_col !== 0 || cursor_row !== 0) begin
      $display("FAIL mid_reset_cell got cell=%0d cur=(%0d,%0d) exp cell=255 cur=(0,0)",
               v, cursor_row, cursor_col); bad++;
    end
  endtask

  task automatic test_read_first();
    logic [7:0] v;
    send(8'd60);
    rd_row = '0; rd_col = 7'd1;
    char_valid = 1'b1; character_id = 8'd61;
    tick();
    char_valid = 1'b0;
    total++;
    if (rd_data !== 8'd255) begin $display("FAIL read_first_old got=%0d exp=255", rd_data); bad++; end
    tick();
    total++;
    if (rd_data !== 8'd61) begin $display("FAIL read_first_new got=%0d exp=61", rd_data); bad++; end
    read_cell(0, 0, v);
    total++;
    if (v !== 8'd60) begin $display("FAIL read_first_prev got=%0d exp=60", v); bad++; end
  endtask

  initial begin
    reset = 1'b1; character_id = '0; char_valid = 1'b0; clear_req = 1'b0;
    rd_col = '0; rd_row = '0;
    test_reset();
    test_basic_write();
    test_row_wrap();
    test_invalid_id();
    test_out_of_range();
    test_clear_with_char();
    test_reset_mid_sweep();
    test_read_first();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
